// File: rtl/mem_bus_if.sv
// MEM-stage data-bus master: one SRAM-like req/addr_ok/data_ok transaction per load/store,
// stalling the pipeline until done and returning the load result aligned and extended.
module mem_bus_if #(
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wen,
    input  logic [3:0]  mem_ren,
    input  logic [31:0] mem_wdata,
    input  logic        mem_sign,
    input  logic        mem_advance,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] rdata_ext,
    output logic        rdata_valid,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic        cancel, cancel_nxt;
    logic        latch, capture;
    logic        request, is_write;
    logic [3:0]  act_en;
    logic [1:0]  size_in;
    logic [31:0] mapped_addr;
    logic [31:0] addr_q, wdata_q, raw, ext;
    logic [3:0]  wstrb_q;
    logic [1:0]  size_q;
    logic        wr_q, sign_q;

    assign request  = mem_valid && ((mem_wen | mem_ren) != 4'b0000);
    assign is_write = (mem_wen != 4'b0000);
    assign act_en   = is_write ? mem_wen : mem_ren;
    assign mapped_addr = (MAP_KSEG && (mem_addr[31:30] == 2'b10)) ?
                         {3'b000, mem_addr[28:0]} : mem_addr;

    always_comb begin
        case (act_en)
            4'b1111:          size_in = 2'd2;
            4'b0011, 4'b1100: size_in = 2'd1;
            default:          size_in = 2'd0;
        endcase
    end

    // Low address bits survive the mapping, so they give the lane offset of the load
    assign raw = data_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    ext = {{24{sign_q & raw[7]}}, raw[7:0]};
            2'd1:    ext = {{16{sign_q & raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            cancel <= 1'b0;
        end else begin
            state  <= state_nxt;
            cancel <= cancel_nxt;
        end
    end

    // A flushed in-flight op cannot be withdrawn; it runs to data_ok and then drops to IDLE
    always_comb begin
        state_nxt  = state;
        cancel_nxt = cancel;
        latch      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (request && !flush) begin
                    latch      = 1'b1;
                    cancel_nxt = 1'b0;
                    state_nxt  = REQ;
                end
            end
            REQ: begin
                if (flush) cancel_nxt = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        if (cancel || flush) begin
                            state_nxt  = IDLE;
                            cancel_nxt = 1'b0;
                        end else begin
                            state_nxt = DONE;
                            capture   = !wr_q;
                        end
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (flush) cancel_nxt = 1'b1;
                if (data_data_ok) begin
                    if (cancel || flush) begin
                        state_nxt  = IDLE;
                        cancel_nxt = 1'b0;
                    end else begin
                        state_nxt = DONE;
                        capture   = !wr_q;
                    end
                end
            end
            DONE: begin
                if (flush || mem_advance) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            size_q    <= 2'd0;
            wr_q      <= 1'b0;
            sign_q    <= 1'b0;
            rdata_ext <= 32'd0;
        end else begin
            if (latch) begin
                addr_q  <= mapped_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wen;
                size_q  <= size_in;
                wr_q    <= is_write;
                sign_q  <= mem_sign;
            end
            if (capture) rdata_ext <= ext;
        end
    end

    assign stall       = resetn && ((state == IDLE && request && !flush) ||
                                    state == REQ || state == WAIT);
    assign data_req    = (state == REQ);
    assign rdata_valid = (state == DONE) && !wr_q && !flush;
    assign data_wr     = wr_q;
    assign data_size   = size_q;
    assign data_addr   = addr_q;
    assign data_wstrb  = wstrb_q;
    assign data_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Self-checking bench for mem_bus_if: table of load/store transactions scored through a
// queue, plus hand-written flush, reset and back-pressure sequences.
module tb_mem_bus_if;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wen, mem_ren;
    logic [31:0] mem_wdata;
    logic        mem_sign, mem_advance, flush;
    logic        stall, rdata_valid, data_req, data_wr;
    logic [31:0] rdata_ext, data_addr, data_wdata, data_rdata;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;

    always #5 clk = ~clk;

    mem_bus_if #(.MAP_KSEG(1'b1)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata), .mem_sign(mem_sign),
        .mem_advance(mem_advance), .flush(flush), .stall(stall), .rdata_ext(rdata_ext),
        .rdata_valid(rdata_valid), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [3:0]  ren;
        logic [31:0] wdata;
        logic        sign;
        logic [31:0] rdata;
        int          addr_wait;
        int          data_wait;
        bit          same;
        logic [31:0] exp_addr;
        logic [1:0]  exp_size;
        logic        exp_wr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[9];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        mem_valid    = 1'b0;
        mem_wen      = 4'd0;
        mem_ren      = 4'd0;
        mem_sign     = 1'b0;
        flush        = 1'b0;
        mem_advance  = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
    endtask

    task automatic checkReq(input vec_t v, input string name);
        check({name, "_ctl"}, {23'd0, data_req, data_wr, data_size, data_wstrb, stall},
              {23'd0, 1'b1, v.exp_wr, v.exp_size, v.exp_wstrb, 1'b1});
        check({name, "_addr"}, data_addr, v.exp_addr);
        check({name, "_wdata"}, data_wdata, v.exp_wdata);
    endtask

    task automatic checkOutput();
        vec_t e;
        int   n = 0;
        #1;
        while (stall && n < 8) begin
            @(negedge clk); #1;
            n++;
        end
        check("done_stall", {31'd0, stall}, 32'd0);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("done_valid", {31'd0, rdata_valid}, {31'd0, e.exp_valid});
            check("done_rdata", rdata_ext, e.exp_rdata);
        end
        mem_advance = 1'b1;
        @(negedge clk);
        idleInputs();
        #1 check("after_adv", {30'd0, stall, rdata_valid}, 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = v.addr;
        mem_wen   = v.wen;
        mem_ren   = v.ren;
        mem_wdata = v.wdata;
        mem_sign  = v.sign;
        #1 check("idle_stall", {31'd0, stall}, 32'd1);
        sb.push_back(v);
        @(negedge clk);
        for (int i = 0; i < v.addr_wait; i++) begin
            #1 checkReq(v, "req_hold");
            @(negedge clk);
        end
        #1 checkReq(v, "req");
        data_addr_ok = 1'b1;
        data_data_ok = v.same;
        data_rdata   = v.same ? v.rdata : 32'h5A5A5A5A;
        @(negedge clk);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (!v.same) begin
            #1 check("wait_ctl", {30'd0, data_req, stall}, 32'd1);
            for (int i = 0; i < v.data_wait; i++) @(negedge clk);
            data_data_ok = 1'b1;
            data_rdata   = v.rdata;
            @(negedge clk);
            data_data_ok = 1'b0;
            data_rdata   = 32'h5A5A5A5A;
        end
        checkOutput();
    endtask

    initial begin
        //          addr          wen     ren     wdata         sg rdata       aw dw same exp_addr     sz wr wstrb   exp_wdata     exp_rdata     vld
        vecs[0] = '{32'h80001004, 4'h0, 4'b1111, 32'h0,        0, 32'hDEADBEEF, 0, 0, 0, 32'h00001004, 2, 0, 4'h0,   32'h0,        32'hDEADBEEF, 1};
        vecs[1] = '{32'h80000003, 4'h0, 4'b1000, 32'h0,        1, 32'h80FFFFFF, 0, 1, 0, 32'h00000003, 0, 0, 4'h0,   32'h0,        32'hFFFFFF80, 1};
        vecs[2] = '{32'h80000003, 4'h0, 4'b1000, 32'h0,        0, 32'h80FFFFFF, 1, 0, 0, 32'h00000003, 0, 0, 4'h0,   32'h0,        32'h00000080, 1};
        vecs[3] = '{32'h80000002, 4'hC, 4'b1100, 32'h12341234, 0, 32'hFFFFFFFF, 5, 0, 0, 32'h00000002, 1, 1, 4'b1100, 32'h12341234, 32'h00000080, 0};
        vecs[4] = '{32'h00000002, 4'h0, 4'b1100, 32'h0,        1, 32'h80011234, 0, 0, 0, 32'h00000002, 1, 0, 4'h0,   32'h0,        32'hFFFF8001, 1};
        vecs[5] = '{32'hA0000000, 4'h0, 4'b0011, 32'h0,        0, 32'h1234F00D, 0, 0, 1, 32'h00000000, 1, 0, 4'h0,   32'h0,        32'h0000F00D, 1};
        vecs[6] = '{32'hC0000001, 4'h0, 4'b0010, 32'h0,        1, 32'h00007F00, 2, 3, 0, 32'hC0000001, 0, 0, 4'h0,   32'h0,        32'h0000007F, 1};
        vecs[7] = '{32'h9FC00010, 4'hF, 4'b0000, 32'hCAFEBABE, 0, 32'h0,        0, 0, 1, 32'h1FC00010, 2, 1, 4'hF,   32'hCAFEBABE, 32'h0000007F, 0};
        vecs[8] = '{32'h00000100, 4'h0, 4'b0001, 32'h0,        1, 32'h123456F0, 0, 0, 0, 32'h00000100, 0, 0, 4'h0,   32'h0,        32'hFFFFFFF0, 1};

        idleInputs();
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        data_rdata = 32'd0;
        resetn     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ctl", {29'd0, stall, data_req, rdata_valid}, 32'd0);
        check("rst_rdata", rdata_ext, 32'd0);
        check("rst_addr", data_addr, 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

        // Valid instruction with no enables: no bus op
        @(negedge clk);
        mem_valid = 1'b1;
        #1 check("noen_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        #1 check("noen_req", {31'd0, data_req}, 32'd0);
        idleInputs();

        // Flush in IDLE suppresses the request
        @(negedge clk);
        mem_valid = 1'b1; mem_ren = 4'hF; mem_addr = 32'h40; flush = 1'b1;
        #1 check("flush_idle_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        idleInputs();
        #1 check("flush_idle_req", {31'd0, data_req}, 32'd0);

        // Flush in WAIT: op completes on the bus, then back to IDLE with no result
        @(negedge clk);
        mem_valid = 1'b1; mem_ren = 4'hF; mem_addr = 32'h10;
        @(negedge clk);
        data_addr_ok = 1'b1;
        @(negedge clk);
        idleInputs();
        flush = 1'b1;
        #1 check("fw_wait", {30'd0, stall, rdata_valid}, 32'd2);
        @(negedge clk);
        flush = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h11111111;
        #1 check("fw_dataok", {30'd0, stall, rdata_valid}, 32'd2);
        @(negedge clk);
        data_data_ok = 1'b0;
        #1 check("fw_after", {29'd0, stall, rdata_valid, data_req}, 32'd0);
        check("fw_rdata_kept", rdata_ext, 32'hFFFFFFF0);
        @(negedge clk);
        #1 check("fw_novalid", {31'd0, rdata_valid}, 32'd0);

        // Flush together with advance in DONE, then a fresh request must start
        @(negedge clk);
        mem_valid = 1'b1; mem_ren = 4'b0001; mem_addr = 32'h0; mem_sign = 1'b0;
        @(negedge clk);
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h000000AB;
        @(negedge clk);
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1 check("fd_rdata", rdata_ext, 32'h000000AB);
        check("fd_valid_pre", {31'd0, rdata_valid}, 32'd1);
        flush = 1'b1; mem_advance = 1'b1;
        #1 check("fd_valid_flush", {30'd0, stall, rdata_valid}, 32'd0);
        @(negedge clk);
        idleInputs();
        mem_valid = 1'b1; mem_ren = 4'hF; mem_addr = 32'h20;
        #1 check("fd_restart_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        #1 check("fd_restart_req", {31'd0, data_req}, 32'd1);

        // Reset while in REQ abandons the op
        resetn = 1'b0;
        @(negedge clk);
        #1 check("rreq_ctl", {29'd0, data_req, stall, rdata_valid}, 32'd0);
        check("rreq_rdata", rdata_ext, 32'd0);
        idleInputs();
        resetn = 1'b1;
        @(negedge clk);
        #1 check("rreq_idle", {30'd0, data_req, stall}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
